// File: rtl/l1_mshr.sv
// L1 miss status holding registers: tracks outstanding line misses from
// allocation through the L2 read and back to a fill presented to the pipeline.
package l1_mshr_pkg;
  typedef enum logic [1:0] {E_FREE, E_ISSUE, E_WAIT, E_FILL} ent_st_e;
endpackage

module l1_mshr_entry
  import l1_mshr_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 512
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_alloc,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [2:0]        i_op,
  input  logic [3:0]        i_way,
  input  logic              i_issue_ack,
  input  logic              i_rsp,
  input  logic [3:0]        i_rsp_state,
  input  logic [LINE_W-1:0] i_rsp_data,
  input  logic              i_fill_ack,
  output ent_st_e           o_st,
  output logic [ADDR_W-1:0] o_addr,
  output logic [2:0]        o_op,
  output logic [3:0]        o_way,
  output logic [3:0]        o_gstate,
  output logic [LINE_W-1:0] o_data
);
  ent_st_e r_st, w_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_st <= E_FREE;
    else        r_st <= w_nxt;
  end

  always_comb begin
    w_nxt = r_st;
    case (r_st)
      E_FREE:  if (i_alloc)     w_nxt = E_ISSUE;
      E_ISSUE: if (i_issue_ack) w_nxt = E_WAIT;
      E_WAIT:  if (i_rsp)       w_nxt = E_FILL;
      E_FILL:  if (i_fill_ack)  w_nxt = E_FREE;
      default:                  w_nxt = E_FREE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_addr   <= '0;
      o_op     <= '0;
      o_way    <= '0;
      o_gstate <= '0;
      o_data   <= '0;
    end else begin
      if (i_alloc && r_st == E_FREE) begin
        o_addr <= i_addr;
        o_op   <= i_op;
        o_way  <= i_way;
      end
      if (i_rsp && r_st == E_WAIT) begin
        o_gstate <= i_rsp_state;
        o_data   <= i_rsp_data;
      end
    end
  end

  assign o_st = r_st;
endmodule

module l1_mshr
  import l1_mshr_pkg::*;
#(
  parameter int ENTRIES = 4,
  parameter int ADDR_W  = 32,
  parameter int LINE_W  = 512,
  parameter int ID_W    = $clog2(ENTRIES)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              alloc_valid,
  input  logic [ADDR_W-1:0] alloc_addr,
  input  logic [2:0]        alloc_op,
  input  logic [3:0]        alloc_way,
  input  logic [ADDR_W-1:0] lookup_addr,
  output logic              mshr_hit,
  output logic              full,
  output logic              l2_req_valid,
  input  logic              l2_req_ready,
  output logic [ADDR_W-1:0] l2_req_addr,
  output logic [2:0]        l2_req_op,
  output logic [ID_W-1:0]   l2_req_id,
  input  logic              l2_rsp_valid,
  input  logic [ID_W-1:0]   l2_rsp_id,
  input  logic [3:0]        l2_rsp_state,
  input  logic [LINE_W-1:0] l2_rsp_data,
  output logic              fill_valid,
  input  logic              fill_ready,
  output logic [ADDR_W-1:0] fill_addr,
  output logic [3:0]        fill_way,
  output logic [2:0]        fill_op,
  output logic [3:0]        fill_state,
  output logic [LINE_W-1:0] fill_data,
  output logic              err
);
  localparam logic [2:0] OP_ST    = 3'd2;
  localparam logic [2:0] OP_RD    = 3'd3;
  localparam logic [2:0] OP_RWITM = 3'd7;

  ent_st_e                       w_st [ENTRIES];
  logic [ENTRIES-1:0][ADDR_W-1:0] w_addr;
  logic [ENTRIES-1:0][2:0]        w_op;
  logic [ENTRIES-1:0][3:0]        w_way;
  logic [ENTRIES-1:0][3:0]        w_gstate;
  logic [ENTRIES-1:0][LINE_W-1:0] w_data;

  logic [ENTRIES-1:0] w_free, w_issue, w_fill, w_dup_m, w_look_m;
  logic [ENTRIES-1:0] w_alloc_en, w_issue_ack, w_rsp_en, w_fill_ack;
  logic [ID_W-1:0]    w_alloc_idx, w_iss_low, w_fill_low, w_iss_idx, w_fill_idx;
  logic               w_dup, w_alloc_ok, w_rsp_ok;

  // Lock the presented entry while stalled, so a lower entry that becomes
  // eligible later cannot swap the request/fill out from under the consumer.
  logic               r_iss_lock, r_fill_lock, r_err;
  logic [ID_W-1:0]    r_iss_idx, r_fill_idx;

  always_comb begin
    w_alloc_idx = '0;
    w_iss_low   = '0;
    w_fill_low  = '0;
    for (int i = ENTRIES-1; i >= 0; i--) begin
      if (w_free[i])  w_alloc_idx = ID_W'(i);
      if (w_issue[i]) w_iss_low   = ID_W'(i);
      if (w_fill[i])  w_fill_low  = ID_W'(i);
    end
  end

  assign full         = ~|w_free;
  assign w_dup        = |w_dup_m;
  assign w_alloc_ok   = alloc_valid & ~full & ~w_dup;
  assign w_rsp_ok     = l2_rsp_valid & (w_st[l2_rsp_id] == E_WAIT);
  assign mshr_hit     = (|w_look_m) | (alloc_valid & (alloc_addr == lookup_addr));

  assign w_iss_idx    = r_iss_lock  ? r_iss_idx  : w_iss_low;
  assign w_fill_idx   = r_fill_lock ? r_fill_idx : w_fill_low;
  assign l2_req_valid = |w_issue;
  assign fill_valid   = |w_fill;

  assign l2_req_addr  = l2_req_valid ? w_addr[w_iss_idx] : '0;
  assign l2_req_op    = !l2_req_valid ? 3'd0 :
                        (w_op[w_iss_idx] == OP_ST) ? OP_RWITM : OP_RD;
  assign l2_req_id    = l2_req_valid ? w_iss_idx : '0;

  assign fill_addr    = fill_valid ? w_addr[w_fill_idx]   : '0;
  assign fill_way     = fill_valid ? w_way[w_fill_idx]    : '0;
  assign fill_op      = fill_valid ? w_op[w_fill_idx]     : '0;
  assign fill_state   = fill_valid ? w_gstate[w_fill_idx] : '0;
  assign fill_data    = fill_valid ? w_data[w_fill_idx]   : '0;
  assign err          = r_err;

  for (genvar g = 0; g < ENTRIES; g++) begin : g_ent
    assign w_free[g]      = (w_st[g] == E_FREE);
    assign w_issue[g]     = (w_st[g] == E_ISSUE);
    assign w_fill[g]      = (w_st[g] == E_FILL);
    assign w_dup_m[g]     = ~w_free[g] & (w_addr[g] == alloc_addr);
    assign w_look_m[g]    = ~w_free[g] & (w_addr[g] == lookup_addr);
    assign w_alloc_en[g]  = w_alloc_ok & (w_alloc_idx == ID_W'(g));
    assign w_issue_ack[g] = l2_req_valid & l2_req_ready & (w_iss_idx == ID_W'(g));
    assign w_rsp_en[g]    = w_rsp_ok & (l2_rsp_id == ID_W'(g));
    assign w_fill_ack[g]  = fill_valid & fill_ready & (w_fill_idx == ID_W'(g));

    l1_mshr_entry #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) u_ent (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_alloc     (w_alloc_en[g]),
      .i_addr      (alloc_addr),
      .i_op        (alloc_op),
      .i_way       (alloc_way),
      .i_issue_ack (w_issue_ack[g]),
      .i_rsp       (w_rsp_en[g]),
      .i_rsp_state (l2_rsp_state),
      .i_rsp_data  (l2_rsp_data),
      .i_fill_ack  (w_fill_ack[g]),
      .o_st        (w_st[g]),
      .o_addr      (w_addr[g]),
      .o_op        (w_op[g]),
      .o_way       (w_way[g]),
      .o_gstate    (w_gstate[g]),
      .o_data      (w_data[g])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_iss_lock  <= 1'b0;
      r_iss_idx   <= '0;
      r_fill_lock <= 1'b0;
      r_fill_idx  <= '0;
      r_err       <= 1'b0;
    end else begin
      r_iss_lock  <= l2_req_valid & ~l2_req_ready;
      r_iss_idx   <= w_iss_idx;
      r_fill_lock <= fill_valid & ~fill_ready;
      r_fill_idx  <= w_fill_idx;
      if ((alloc_valid & (full | w_dup)) | (l2_rsp_valid & ~w_rsp_ok))
        r_err <= 1'b1;
    end
  end
endmodule
